riu_master: RTL and testbench
=============================

// Module: riu_master
// PURPOSE
// Register-interface initiator for the PHY nibble RIU bus. Turns single-beat request/response transactions
// from the calibration/control logic into RIU write strobes and RIU reads, driving address, write data and
// nibble select. Collects read data from the ORed lower/upper nibble return path and reports a timeout if
// no read-valid returns.
// PARAMETERS
// ADDR_WIDTH  6   RIU register address width
// DATA_WIDTH  16  RIU data width, write and read
// TIMEOUT     15  max cycles after read issue to wait for RIU_RD_VALID; legal 1..255
// PORTS
// RIU_CLK         in   1           RIU clock; all logic rising-edge
// RST_N           in   1           asynchronous active-low reset
// REQ_VALID       in   1           request valid
// REQ_READY       out  1           request accepted when VALID&READY at rising edge
// REQ_WE          in   1           1 = write, 0 = read
// REQ_ADDR        in   ADDR_WIDTH  register address
// REQ_NIBBLE      in   2           nibble select, bit0 = lower, bit1 = upper
// REQ_WDATA       in   DATA_WIDTH  write data
// RSP_VALID       out  1           response valid, held until RSP_READY
// RSP_READY       in   1           response consumed when VALID&READY at rising edge
// RSP_RDATA       out  DATA_WIDTH  read data; 0 for writes and errors
// RSP_ERR         out  1           1 = illegal nibble select or read timeout
// RIU_ADDR        out  ADDR_WIDTH  to nibbles
// RIU_WR_DATA     out  DATA_WIDTH  to nibbles
// RIU_WR_EN       out  1           one-cycle write strobe
// RIU_NIBBLE_SEL  out  2           to nibbles
// RIU_RD_DATA     in   DATA_WIDTH  ORed read data from both nibbles
// RIU_RD_VALID    in   1           ORed read valid from both nibbles
// BEHAVIOUR
// - Reset (RST_N low, async): state IDLE; all outputs 0, including REQ_READY; timeout counter 0.
//   Reset mid-transaction aborts it with no response.
// - REQ_READY = RST_N & (state==IDLE). Accepted request fields are latched, and REQ_* are ignored afterwards.
// - States:
//   - IDLE -> WR on write when REQ_NIBBLE!=0.
//   - IDLE -> RD_ISSUE on read when REQ_NIBBLE is 01 or 10.
//   - IDLE -> RESP with ERR=1 on REQ_NIBBLE==00, or on a read with 11. No bus activity in these cases.
//   - WR -> RESP.
//   - RD_ISSUE -> RD_WAIT.
//   - RD_WAIT -> RESP on RIU_RD_VALID or timeout.
//   - RESP -> IDLE on RSP_READY.
// - Idle bus: RIU_ADDR, RIU_WR_DATA, RIU_NIBBLE_SEL and RIU_WR_EN are all 0, so nibbles return 0 into the OR.
// - Write: in the cycle after accept (WR), RIU_WR_EN=1 with ADDR/WR_DATA/NIBBLE_SEL valid, exactly one cycle.
//   RSP_VALID=1 from the next cycle, with ERR=0 and RDATA=0. NIBBLE_SEL=11 broadcasts to both nibbles.
// - Read: RD_ISSUE cycle drives ADDR and NIBBLE_SEL with WR_EN=0. ADDR and NIBBLE_SEL stay held through RD_WAIT.
// - RIU_RD_VALID is sampled only in RD_ISSUE/RD_WAIT. The first high sample captures RIU_RD_DATA into RSP_RDATA.
//   RSP_VALID is 1 the following cycle with ERR=0. RIU_RD_VALID in any other state is ignored.
// - Timeout: an 8-bit counter clears on entering RD_ISSUE and increments each RD_ISSUE/RD_WAIT cycle.
//   If it reaches TIMEOUT with no valid, the block responds ERR=1, RDATA=0.
//   If valid arrives in the same cycle as expiry, the data wins and ERR=0.
// - On leaving RD_WAIT or WR, the bus outputs return to 0.
// - Latency, accept edge at cycle 0:
//   - Write: WR_EN in cycle 1, RSP_VALID from cycle 2.
//   - Read: issue in cycle 1; valid sampled in cycle k (k>=1) gives RSP_VALID from cycle k+1.
//   - Illegal nibble: RSP_VALID from cycle 1.
// - Back-pressure: while RSP_READY=0, RSP_* stay stable and REQ_READY=0. One transaction is outstanding at most.
// - Single-cycle RSP handshake: RSP_VALID drops the next cycle, and REQ_READY rises in that same cycle.
// TESTING
// - Write addr 0x12, nibble 01, data 0xA5C3: RIU_WR_EN high 1 cycle at cycle 1 with those values.
//   RSP_VALID at cycle 2, ERR=0, RDATA=0.
// - Read addr 0x05, nibble 10: the responder asserts RD_VALID 3 cycles after issue with 0x1234.
//   RSP_RDATA=0x1234, ERR=0, RSP_VALID one cycle after valid.
// - Read with no responder, TIMEOUT=15: RSP_VALID with ERR=1, RDATA=0 after 15 wait cycles.
//   Repeat with valid landing on the expiry cycle -> ERR=0.
// - REQ_NIBBLE=00 write and 11 read: immediate ERR=1 response and no RIU_WR_EN or NIBBLE_SEL activity.
//   A write with 11 asserts NIBBLE_SEL=11.
// - RSP_READY held low 10 cycles: RSP_* stable and REQ_READY=0 throughout.
//   A request is accepted the cycle after the handshake.
// - RST_N pulsed low during RD_WAIT: all outputs 0 immediately and no response.
//   A later stray RIU_RD_VALID is ignored, and the next read completes normally.

Source files
------------

// File: rtl/riu_master_if.sv
// Request/response and RIU nibble bus bundle for riu_master.
// master = the initiator view, slave = requester plus nibble side.
interface riu_master_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
);
  logic                  REQ_VALID;
  logic                  REQ_READY;
  logic                  REQ_WE;
  logic [ADDR_WIDTH-1:0] REQ_ADDR;
  logic [1:0]            REQ_NIBBLE;
  logic [DATA_WIDTH-1:0] REQ_WDATA;
  logic                  RSP_VALID;
  logic                  RSP_READY;
  logic [DATA_WIDTH-1:0] RSP_RDATA;
  logic                  RSP_ERR;
  logic [ADDR_WIDTH-1:0] RIU_ADDR;
  logic [DATA_WIDTH-1:0] RIU_WR_DATA;
  logic                  RIU_WR_EN;
  logic [1:0]            RIU_NIBBLE_SEL;
  logic [DATA_WIDTH-1:0] RIU_RD_DATA;
  logic                  RIU_RD_VALID;

  modport master (
    input  REQ_VALID, REQ_WE, REQ_ADDR,
    input  REQ_NIBBLE, REQ_WDATA,
    input  RSP_READY,
    input  RIU_RD_DATA, RIU_RD_VALID,
    output REQ_READY,
    output RSP_VALID, RSP_RDATA, RSP_ERR,
    output RIU_ADDR, RIU_WR_DATA,
    output RIU_WR_EN, RIU_NIBBLE_SEL
  );

  modport slave (
    output REQ_VALID, REQ_WE, REQ_ADDR,
    output REQ_NIBBLE, REQ_WDATA,
    output RSP_READY,
    output RIU_RD_DATA, RIU_RD_VALID,
    input  REQ_READY,
    input  RSP_VALID, RSP_RDATA, RSP_ERR,
    input  RIU_ADDR, RIU_WR_DATA,
    input  RIU_WR_EN, RIU_NIBBLE_SEL
  );
endinterface

// File: rtl/riu_master.sv
// Single-beat RIU initiator: write strobes, reads with timeout,
// one outstanding transaction, registered bus and response outputs.
module riu_master #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic          RIU_CLK,
  input  logic          RST_N,
  riu_master_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RESP
  } state_e;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wen_q, wen_d;
  logic [1:0]            sel_q, sel_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [7:0]            cnt_q, cnt_d;

  logic       wr_ok;
  logic       rd_ok;
  logic [7:0] cnt_inc;

  assign wr_ok = bus.REQ_WE & (bus.REQ_NIBBLE != 2'b00);
  assign rd_ok = ~bus.REQ_WE
               & (bus.REQ_NIBBLE[0] ^ bus.REQ_NIBBLE[1]);
  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wen_d       = wen_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.REQ_VALID) begin
          unique case (1'b1)
            wr_ok: begin
              state_d = S_WR;
              addr_d  = bus.REQ_ADDR;
              wdata_d = bus.REQ_WDATA;
              sel_d   = bus.REQ_NIBBLE;
              wen_d   = 1'b1;
            end
            rd_ok: begin
              state_d = S_RD_ISSUE;
              addr_d  = bus.REQ_ADDR;
              sel_d   = bus.REQ_NIBBLE;
              cnt_d   = 8'd0;
            end
            default: begin
              // illegal select: answer at once, bus untouched
              state_d     = S_RESP;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
              rsp_rdata_d = '0;
            end
          endcase
        end
      end
      S_WR: begin
        state_d     = S_RESP;
        addr_d      = '0;
        wdata_d     = '0;
        sel_d       = '0;
        wen_d       = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
      end
      S_RD_ISSUE, S_RD_WAIT: begin
        cnt_d = cnt_inc;
        if (bus.RIU_RD_VALID) begin
          state_d     = S_RESP;
          addr_d      = '0;
          sel_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = bus.RIU_RD_DATA;
        end else if (cnt_inc == TMO) begin
          state_d     = S_RESP;
          addr_d      = '0;
          sel_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          state_d = S_RD_WAIT;
        end
      end
      S_RESP: begin
        if (bus.RSP_READY) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge RIU_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wen_q       <= 1'b0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wen_q       <= wen_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.REQ_READY      = RST_N & (state_q == S_IDLE);
  assign bus.RSP_VALID      = rsp_valid_q;
  assign bus.RSP_RDATA      = rsp_rdata_q;
  assign bus.RSP_ERR        = rsp_err_q;
  assign bus.RIU_ADDR       = addr_q;
  assign bus.RIU_WR_DATA    = wdata_q;
  assign bus.RIU_WR_EN      = wen_q;
  assign bus.RIU_NIBBLE_SEL = sel_q;

endmodule

// File: tb/tb_riu_master.sv
// Bench for riu_master: directed vector table, random transactions
// against a transaction-level model, and a mid-read reset sequence.
module tb_riu_master;
  localparam int AW  = 6;
  localparam int DW  = 16;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riu_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  riu_master #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT(TMO)
  ) dut (
    .RIU_CLK(clk),
    .RST_N(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [1:0]    nib;
    logic [DW-1:0] wdata;
    int            delay;
    logic [DW-1:0] rdata_in;
    int            hold;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
    int            exp_lat;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] bus_now();
    return 64'({bus.RIU_ADDR, bus.RIU_WR_DATA,
                bus.RIU_WR_EN, bus.RIU_NIBBLE_SEL});
  endfunction

  // Transaction-level view: latency counted from the accept edge.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    logic wr = v.we && v.nib != 2'b00;
    logic rd = !v.we && (v.nib == 2'b01 || v.nib == 2'b10);
    if (wr) begin
      r.exp_lat = 2; r.exp_err = 1'b0; r.exp_rdata = '0;
    end else if (rd && v.delay >= 1 && v.delay <= TMO) begin
      r.exp_lat = v.delay + 1; r.exp_err = 1'b0;
      r.exp_rdata = v.rdata_in;
    end else if (rd) begin
      r.exp_lat = TMO + 1; r.exp_err = 1'b1; r.exp_rdata = '0;
    end else begin
      r.exp_lat = 1; r.exp_err = 1'b1; r.exp_rdata = '0;
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic we, input logic [AW-1:0] a,
                              input logic [1:0] n, input logic [DW-1:0] wd,
                              input int d, input logic [DW-1:0] ri,
                              input int h, input logic e,
                              input logic [DW-1:0] er, input int l);
    vec_t v;
    v.we = we; v.addr = a; v.nib = n; v.wdata = wd;
    v.delay = d; v.rdata_in = ri; v.hold = h;
    v.exp_err = e; v.exp_rdata = er; v.exp_lat = l;
    return v;
  endfunction

  // Entered at a negedge with the block idle; returns at the negedge
  // of the cycle after the response handshake (idle again).
  task automatic run(input vec_t v, input string tag);
    logic wr_ok, rd_ok;
    logic [63:0] eb;
    int h;
    wr_ok = v.we && v.nib != 2'b00;
    rd_ok = !v.we && (v.nib == 2'b01 || v.nib == 2'b10);
    h = v.exp_lat + v.hold;
    chk({tag, "/req_ready0"}, 64'(bus.REQ_READY), 64'(1));
    chk({tag, "/bus0"}, bus_now(), 64'(0));
    bus.REQ_VALID = 1'b1;
    bus.REQ_WE = v.we;
    bus.REQ_ADDR = v.addr;
    bus.REQ_NIBBLE = v.nib;
    bus.REQ_WDATA = v.wdata;
    bus.RSP_READY = 1'b0;
    bus.RIU_RD_VALID = 1'($urandom_range(0, 1));
    bus.RIU_RD_DATA = DW'($urandom);
    for (int c = 1; c <= h + 1; c++) begin
      @(negedge clk);
      eb = 64'(0);
      if (wr_ok && c == 1)
        eb = 64'({v.addr, v.wdata, 1'b1, v.nib});
      else if (rd_ok && c < v.exp_lat)
        eb = 64'({v.addr, {DW{1'b0}}, 1'b0, v.nib});
      chk($sformatf("%s/bus c%0d", tag, c), bus_now(), eb);
      chk($sformatf("%s/req_ready c%0d", tag, c),
          64'(bus.REQ_READY), 64'(c == h + 1));
      chk($sformatf("%s/rsp_valid c%0d", tag, c),
          64'(bus.RSP_VALID), 64'(c >= v.exp_lat && c <= h));
      if (c >= v.exp_lat && c <= h) begin
        chk($sformatf("%s/rdata c%0d", tag, c),
            64'(bus.RSP_RDATA), 64'(v.exp_rdata));
        chk($sformatf("%s/err c%0d", tag, c),
            64'(bus.RSP_ERR), 64'(v.exp_err));
      end
      if (c <= h) begin
        bus.REQ_VALID = 1'($urandom_range(0, 1));
        bus.REQ_WE = 1'($urandom_range(0, 1));
        bus.REQ_ADDR = AW'($urandom);
        bus.REQ_NIBBLE = 2'($urandom);
        bus.REQ_WDATA = DW'($urandom);
      end else begin
        bus.REQ_VALID = 1'b0;
      end
      if (c == v.delay) begin
        bus.RIU_RD_VALID = 1'b1;
        bus.RIU_RD_DATA = v.rdata_in;
      end else begin
        bus.RIU_RD_VALID = (!rd_ok || c >= v.exp_lat)
                         ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.RIU_RD_DATA = DW'($urandom);
      end
      if (c >= h && c <= h) bus.RSP_READY = 1'b1;
      else if (c < v.exp_lat) bus.RSP_READY = 1'($urandom_range(0, 1));
      else bus.RSP_READY = 1'b0;
    end
    bus.RSP_READY = 1'b0;
    bus.RIU_RD_VALID = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "/req_ready"}, 64'(bus.REQ_READY), 64'(0));
    chk({tag, "/rsp_valid"}, 64'(bus.RSP_VALID), 64'(0));
    chk({tag, "/rsp_rdata"}, 64'(bus.RSP_RDATA), 64'(0));
    chk({tag, "/rsp_err"}, 64'(bus.RSP_ERR), 64'(0));
    chk({tag, "/bus"}, bus_now(), 64'(0));
  endtask

  initial begin
    vec_t v;
    tbl[0]  = mk(1, 6'h12, 2'b01, 16'hA5C3, 0, 16'h0000, 0, 0, 16'h0000, 2);
    tbl[1]  = mk(0, 6'h05, 2'b10, 16'h0000, 4, 16'h1234, 0, 0, 16'h1234, 5);
    tbl[2]  = mk(0, 6'h3A, 2'b01, 16'h0000, 0, 16'h0000, 1, 1, 16'h0000, 16);
    tbl[3]  = mk(0, 6'h3A, 2'b01, 16'h0000, 15, 16'hBEEF, 0, 0, 16'hBEEF, 16);
    tbl[4]  = mk(1, 6'h07, 2'b00, 16'hFFFF, 0, 16'h0000, 0, 1, 16'h0000, 1);
    tbl[5]  = mk(0, 6'h08, 2'b11, 16'h0000, 1, 16'h5555, 0, 1, 16'h0000, 1);
    tbl[6]  = mk(1, 6'h3F, 2'b11, 16'h0F0F, 0, 16'h0000, 0, 0, 16'h0000, 2);
    tbl[7]  = mk(1, 6'h2C, 2'b10, 16'h1357, 0, 16'h0000, 10, 0, 16'h0000, 2);
    tbl[8]  = mk(0, 6'h01, 2'b01, 16'h0000, 1, 16'h8001, 2, 0, 16'h8001, 2);
    tbl[9]  = mk(0, 6'h02, 2'b00, 16'h0000, 0, 16'h0000, 0, 1, 16'h0000, 1);
    tbl[10] = mk(0, 6'h3F, 2'b10, 16'h0000, 16, 16'hABCD, 0, 1, 16'h0000, 16);

    bus.REQ_VALID = 1'b0;
    bus.REQ_WE = 1'b0;
    bus.REQ_ADDR = '0;
    bus.REQ_NIBBLE = '0;
    bus.REQ_WDATA = '0;
    bus.RSP_READY = 1'b0;
    bus.RIU_RD_DATA = '0;
    bus.RIU_RD_VALID = 1'b0;

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++)
      run(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      v.we = 1'($urandom_range(0, 1));
      v.addr = AW'($urandom);
      v.nib = 2'($urandom);
      v.wdata = DW'($urandom);
      v.delay = $urandom_range(0, TMO + 3);
      v.rdata_in = DW'($urandom);
      v.hold = $urandom_range(0, 3);
      run(model(v), $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a read wait.
    bus.REQ_VALID = 1'b1;
    bus.REQ_WE = 1'b0;
    bus.REQ_ADDR = 6'h21;
    bus.REQ_NIBBLE = 2'b01;
    @(negedge clk);
    bus.REQ_VALID = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid/bus_held", bus_now(),
        64'({6'h21, 16'h0000, 1'b0, 2'b01}));
    rst_n = 1'b0;
    #1;
    chk_all_zero("rstmid");
    @(negedge clk);
    rst_n = 1'b1;
    bus.RIU_RD_VALID = 1'b1;
    bus.RIU_RD_DATA = 16'hDEAD;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("stray/rsp_valid c%0d", c),
          64'(bus.RSP_VALID), 64'(0));
      chk($sformatf("stray/bus c%0d", c), bus_now(), 64'(0));
      chk($sformatf("stray/req_ready c%0d", c),
          64'(bus.REQ_READY), 64'(1));
    end
    bus.RIU_RD_VALID = 1'b0;
    run(mk(0, 6'h21, 2'b01, 16'h0000, 2, 16'h0F0F, 0, 0, 16'h0F0F, 3),
        "after_rst");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
